// File: rtl/arb_resp_router.sv
// In-order response router: tracks the winning input of each issued request and
// steers returning responses to it. Optional macro ARB_RESP_ROUTER_SPURIOUS_EN.
module arb_resp_router #(
    parameter int NumIn    = 4,
    parameter int MaxTxns  = 8,
    parameter int RspWidth = 32,
    localparam int IdxWidth = $clog2(NumIn),
    localparam int CntWidth = $clog2(MaxTxns + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    input  logic [IdxWidth-1:0] issue_idx_i,
    output logic                issue_ready_o,
    input  logic                rsp_valid_i,
    output logic                rsp_ready_o,
    input  logic [RspWidth-1:0] rsp_data_i,
    output logic [NumIn-1:0]    rsp_valid_o,
    input  logic [NumIn-1:0]    rsp_ready_i,
    output logic [RspWidth-1:0] rsp_data_o,
    output logic [CntWidth-1:0] outstanding_o,
    output logic                err_o
);
    localparam int PtrWidth = $clog2(MaxTxns);

    logic [IdxWidth-1:0] mem [MaxTxns];
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic [CntWidth-1:0] count;
    logic                head_vld;
    logic [IdxWidth-1:0] head_idx;
    logic                push;
    logic                pop;

    assign head_vld      = (count != '0);
    assign head_idx      = mem[rd_ptr];
    assign issue_ready_o = (count != CntWidth'(MaxTxns));
    assign push          = issue_valid_i & issue_ready_o;
    assign pop           = rsp_valid_i & rsp_ready_o & head_vld;
    assign rsp_data_o    = rsp_data_i;
    assign outstanding_o = count;

    always_comb begin
        rsp_valid_o = '0;
        if (rsp_valid_i && head_vld) begin
            rsp_valid_o[head_idx] = 1'b1;
        end
    end

`ifdef ARB_RESP_ROUTER_SPURIOUS_EN
    logic err;

    // While empty, any response beat is swallowed and flagged.
    assign rsp_ready_o = head_vld ? rsp_ready_i[head_idx] : rsp_valid_i;
    assign err_o       = err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err <= 1'b0;
        end else if (rsp_valid_i && !head_vld) begin
            err <= 1'b1;
        end
    end
`else
    assign rsp_ready_o = head_vld & rsp_ready_i[head_idx];
    assign err_o       = 1'b0;

`ifndef SYNTHESIS
    spurious_rsp_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(rsp_valid_i && !head_vld));
`endif
`endif

    // Index storage is data: written on push only, never cleared.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= issue_idx_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_arb_resp_router.sv
// Bench for arb_resp_router: directed scenarios plus a randomized run checked
// against a queue-based model of the outstanding transactions.
module tb_arb_resp_router;
    localparam int NI = 4;
    localparam int MT = 8;
    localparam int RW = 32;
`ifdef ARB_RESP_ROUTER_SPURIOUS_EN
    localparam bit SPUR = 1'b1;
`else
    localparam bit SPUR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid;
    logic [1:0]    issue_idx;
    logic          issue_ready;
    logic          rsp_valid_in;
    logic          rsp_ready_out;
    logic [RW-1:0] rsp_data_in;
    logic [NI-1:0] rsp_valid_out;
    logic [NI-1:0] rsp_ready_in;
    logic [RW-1:0] rsp_data_out;
    logic [3:0]    outstanding;
    logic          err;

    int total = 0;
    int bad   = 0;
    int q[$];
    bit err_m = 1'b0;

    arb_resp_router #(.NumIn(NI), .MaxTxns(MT), .RspWidth(RW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .issue_valid_i (issue_valid),
        .issue_idx_i   (issue_idx),
        .issue_ready_o (issue_ready),
        .rsp_valid_i   (rsp_valid_in),
        .rsp_ready_o   (rsp_ready_out),
        .rsp_data_i    (rsp_data_in),
        .rsp_valid_o   (rsp_valid_out),
        .rsp_ready_i   (rsp_ready_in),
        .rsp_data_o    (rsp_data_out),
        .outstanding_o (outstanding),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    // Reference model: the queue holds the input index of every outstanding transaction.
    function automatic logic [NI-1:0] exp_vld();
        exp_vld = '0;
        if (rsp_valid_in && q.size() > 0) exp_vld = NI'(1) << q[0];
    endfunction

    function automatic logic exp_rrdy();
        if (q.size() > 0) return rsp_ready_in[q[0]];
        return SPUR && rsp_valid_in;
    endfunction

    function automatic void model_edge();
        bit pu;
        bit po;
        if (rst) begin
            q.delete();
            err_m = 1'b0;
            return;
        end
        pu = issue_valid && (q.size() < MT);
        po = rsp_valid_in && (q.size() > 0) && rsp_ready_in[q[0]];
        if (SPUR && rsp_valid_in && q.size() == 0) err_m = 1'b1;
        if (po) void'(q.pop_front());
        if (pu) q.push_back(int'(issue_idx));
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        issue_valid  = 1'b0;
        issue_idx    = '0;
        rsp_valid_in = 1'b0;
        rsp_ready_in = '0;
        rsp_data_in  = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        #2;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_issue_ready got=%b want=1", issue_ready); end
        total++; if (rsp_valid_out !== 4'b0000) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0000", rsp_valid_out); end
        total++; if (rsp_ready_out !== 1'b0) begin bad++; $display("FAIL reset_rsp_ready got=%b want=0", rsp_ready_out); end
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL reset_outstanding got=%0d want=0", outstanding); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    endtask

    task automatic test_in_order();
        int            idxs[3] = '{2, 0, 3};
        logic [NI-1:0] ev[3]   = '{4'b0100, 4'b0001, 4'b1000};
        logic [RW-1:0] d;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1'b1;
            issue_idx   = 2'(idxs[i]);
            cycle();
        end
        issue_valid  = 1'b0;
        rsp_ready_in = '1;
        for (int i = 0; i < 3; i++) begin
            d            = 32'hD000_0000 + 32'(i);
            rsp_valid_in = 1'b1;
            rsp_data_in  = d;
            #2;
            total++; if (rsp_valid_out !== ev[i]) begin bad++; $display("FAIL order_vld[%0d] got=%b want=%b", i, rsp_valid_out, ev[i]); end
            total++; if (rsp_data_out !== d) begin bad++; $display("FAIL order_data[%0d] got=%h want=%h", i, rsp_data_out, d); end
            cycle();
        end
        rsp_valid_in = 1'b0;
        #2;
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL order_drained got=%0d want=0", outstanding); end
    endtask

    task automatic test_full();
        do_reset();
        rsp_ready_in = '1;
        for (int i = 0; i < MT; i++) begin
            issue_valid = 1'b1;
            issue_idx   = 2'($urandom_range(0, 3));
            cycle();
        end
        #2;
        total++; if (outstanding !== 4'd8) begin bad++; $display("FAIL full_count got=%0d want=8", outstanding); end
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", issue_ready); end
        issue_idx = 2'($urandom_range(0, 3));
        cycle();
        issue_valid = 1'b0;
        #2;
        total++; if (outstanding !== 4'd8) begin bad++; $display("FAIL full_ninth_ignored got=%0d want=8", outstanding); end
        rsp_valid_in = 1'b1;
        rsp_data_in  = $urandom;
        #1;
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL full_pop_ready got=%b want=0", issue_ready); end
        cycle();
        rsp_valid_in = 1'b0;
        #2;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL full_ready_rise got=%b want=1", issue_ready); end
        total++; if (outstanding !== 4'd7) begin bad++; $display("FAIL full_after_pop got=%0d want=7", outstanding); end
        rsp_valid_in = 1'b1;
        for (int i = 0; i < MT - 1; i++) begin
            rsp_data_in = $urandom;
            #2;
            total++; if (rsp_valid_out !== exp_vld()) begin bad++; $display("FAIL full_drain_vld[%0d] got=%b want=%b", i, rsp_valid_out, exp_vld()); end
            cycle();
        end
        rsp_valid_in = 1'b0;
        #2;
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL full_drained got=%0d want=0", outstanding); end
    endtask

    task automatic test_push_pop();
        int            idxs[3] = '{1, 2, 3};
        logic [NI-1:0] ev[3]   = '{4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1'b1;
            issue_idx   = 2'(idxs[i]);
            cycle();
        end
        issue_idx    = 2'd0;
        rsp_valid_in = 1'b1;
        rsp_ready_in = '1;
        #2;
        total++; if (rsp_valid_out !== 4'b0010) begin bad++; $display("FAIL pushpop_old_head got=%b want=0010", rsp_valid_out); end
        cycle();
        issue_valid = 1'b0;
        #2;
        total++; if (outstanding !== 4'd3) begin bad++; $display("FAIL pushpop_count got=%0d want=3", outstanding); end
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (rsp_valid_out !== ev[i]) begin bad++; $display("FAIL pushpop_drain[%0d] got=%b want=%b", i, rsp_valid_out, ev[i]); end
            cycle();
        end
        rsp_valid_in = 1'b0;
    endtask

    task automatic test_head_block();
        do_reset();
        issue_valid = 1'b1;
        issue_idx   = 2'd1;
        cycle();
        issue_valid  = 1'b0;
        rsp_valid_in = 1'b1;
        rsp_ready_in = 4'b1101;
        #2;
        total++; if (rsp_ready_out !== 1'b0) begin bad++; $display("FAIL block_ready got=%b want=0", rsp_ready_out); end
        total++; if (rsp_valid_out !== 4'b0010) begin bad++; $display("FAIL block_vld got=%b want=0010", rsp_valid_out); end
        cycle();
        #1;
        total++; if (outstanding !== 4'd1) begin bad++; $display("FAIL block_held got=%0d want=1", outstanding); end
        rsp_ready_in = 4'b0010;
        #1;
        total++; if (rsp_ready_out !== 1'b1) begin bad++; $display("FAIL block_release got=%b want=1", rsp_ready_out); end
        cycle();
        rsp_valid_in = 1'b0;
        #2;
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL block_popped got=%0d want=0", outstanding); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            issue_valid = 1'b1;
            issue_idx   = 2'd3;
            cycle();
        end
        issue_valid = 1'b0;
        #2;
        total++; if (outstanding !== 4'd5) begin bad++; $display("FAIL midrst_before got=%0d want=5", outstanding); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL midrst_count got=%0d want=0", outstanding); end
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", issue_ready); end
        rsp_valid_in = 1'b1;
        rsp_ready_in = '1;
        #1;
        total++; if (rsp_valid_out !== 4'b0000) begin bad++; $display("FAIL midrst_stale got=%b want=0000", rsp_valid_out); end
        rsp_valid_in = 1'b0;
        issue_valid  = 1'b1;
        issue_idx    = 2'd2;
        cycle();
        issue_valid  = 1'b0;
        rsp_valid_in = 1'b1;
        #2;
        total++; if (rsp_valid_out !== 4'b0100) begin bad++; $display("FAIL midrst_new_route got=%b want=0100", rsp_valid_out); end
        cycle();
        rsp_valid_in = 1'b0;
    endtask

    task automatic test_spurious();
        do_reset();
        rsp_valid_in = 1'b1;
        rsp_ready_in = '1;
        rsp_data_in  = 32'hBAD0_0001;
        #2;
        total++; if (rsp_ready_out !== SPUR) begin bad++; $display("FAIL spur_ready got=%b want=%b", rsp_ready_out, SPUR); end
        total++; if (rsp_valid_out !== 4'b0000) begin bad++; $display("FAIL spur_vld got=%b want=0000", rsp_valid_out); end
        if (!SPUR) rsp_valid_in = 1'b0;
        cycle();
        rsp_valid_in = 1'b0;
        #2;
        total++; if (err !== SPUR) begin bad++; $display("FAIL spur_err got=%b want=%b", err, SPUR); end
        issue_valid = 1'b1;
        issue_idx   = 2'd0;
        cycle();
        issue_valid  = 1'b0;
        rsp_valid_in = 1'b1;
        cycle();
        rsp_valid_in = 1'b0;
        #2;
        total++; if (err !== SPUR) begin bad++; $display("FAIL spur_sticky got=%b want=%b", err, SPUR); end
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL spur_count got=%0d want=0", outstanding); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            issue_valid  = ($urandom_range(0, 9) < 6);
            issue_idx    = 2'($urandom_range(0, 3));
            rsp_valid_in = ($urandom_range(0, 1) == 1) && (SPUR || q.size() > 0);
            rsp_ready_in = 4'($urandom);
            rsp_data_in  = $urandom;
            #2;
            total++; if (issue_ready !== (q.size() != MT)) begin bad++; $display("FAIL rnd_issue_ready[%0d] got=%b want=%b", i, issue_ready, q.size() != MT); end
            total++; if (outstanding !== 4'(q.size())) begin bad++; $display("FAIL rnd_count[%0d] got=%0d want=%0d", i, outstanding, q.size()); end
            total++; if (rsp_valid_out !== exp_vld()) begin bad++; $display("FAIL rnd_vld[%0d] got=%b want=%b", i, rsp_valid_out, exp_vld()); end
            total++; if (rsp_ready_out !== exp_rrdy()) begin bad++; $display("FAIL rnd_rsp_ready[%0d] got=%b want=%b", i, rsp_ready_out, exp_rrdy()); end
            total++; if (err !== err_m) begin bad++; $display("FAIL rnd_err[%0d] got=%b want=%b", i, err, err_m); end
            cycle();
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_in_order();
        test_full();
        test_push_pop();
        test_head_block();
        test_reset_mid();
        test_spurious();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
